// File: rtl/aes_inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: one 32-bit column datapath time-shared over the four columns.
// Latency: out_valid rises 4 cycles after the input handshake; next accept 6 cycles after the last.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Option: AES_INVMIX_ADDKEY_EN.
module aes_inv_mix_columns_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
`ifdef AES_INVMIX_ADDKEY_EN
   input  logic [127:0] round_key,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [127:0] src_q, src_d;
   logic [127:0] res_q, res_d;
   logic [1:0]   col_q, col_d;

   logic [127:0] src_load;
   logic [31:0]  col_in;
   logic [31:0]  col_out;

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse mix of one column; byte 0 sits in the LSB. Constants built from x2/x4/x8 chains.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a   [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]   = c[8*i +: 8];
         x2     = xtime(a[i]);
         x4     = xtime(x2);
         x8     = xtime(x4);
         m09[i] = x8 ^ a[i];
         m0b[i] = x8 ^ x2 ^ a[i];
         m0d[i] = x8 ^ x4 ^ a[i];
         m0e[i] = x8 ^ x4 ^ x2;
      end
      return {m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3],
              m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
              m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
              m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3]};
   endfunction

`ifdef AES_INVMIX_ADDKEY_EN
   // AddRoundKey folded into the capture so the column pass sees the keyed state.
   assign src_load = in_data ^ round_key;
`else
   assign src_load = in_data;
`endif

   // The single shared column datapath, steered by the column index.
   always_comb begin
      col_in  = src_q[{col_q, 5'd0} +: 32];
      col_out = inv_mix_col(col_in);
   end

   // Next-state logic: capture in IDLE, one column per cycle in BUSY, hold result in DONE.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      res_d   = res_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               src_d   = src_load;
               col_d   = 2'd0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            res_d[{col_q, 5'd0} +: 32] = col_out;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight and clears the partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         res_q   <= '0;
         col_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         res_q   <= res_d;
         col_q   <= col_d;
      end
   end

   // Handshake outputs decode registered state only, so no input-to-output combinational path.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_data  = res_q;
   end

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
module tb_aes_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] round_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   always #5 clk = ~clk;

`ifdef AES_INVMIX_ADDKEY_EN
   localparam bit ADDKEY = 1'b1;
`else
   localparam bit ADDKEY = 1'b0;
`endif

   aes_inv_mix_columns_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef AES_INVMIX_ADDKEY_EN
      .round_key (round_key),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: generic shift-and-add GF(2^8) product, reduced by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   // Reference InvMixColumns over the full state using the circulant coefficient matrix.
   function automatic logic [127:0] model(input logic [127:0] s);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(coef[(k - row) & 3], s[32*c + 8*k +: 8]);
            r[32*c + 8*row +: 8] = acc;
         end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Cycle-level expectation: busy from accept until the output handshake.
   int           cyc = 0;
   bit           pending = 1'b0;
   int           acc_cyc = 0;
   logic [127:0] exp_res = '0;
   int           acc_q[$];

   // Compare process: checks handshake outputs and held result every cycle.
   always @(negedge clk) begin
      cyc++;
      if (rst_n === 1'b0) begin
         pending = 1'b0;
         chk("rst_out_valid", 128'(out_valid), 128'd0);
         chk("rst_out_data", out_data, 128'd0);
      end else if (rst_n === 1'b1) begin
         chk("mon_in_ready", 128'(in_ready), 128'(!pending));
         chk("mon_out_valid", 128'(out_valid), 128'(pending && (cyc >= acc_cyc + 5)));
         if (pending && (cyc >= acc_cyc + 5))
            chk("mon_out_data", out_data, exp_res);
         if (!pending && in_valid) begin
            pending = 1'b1;
            acc_cyc = cyc;
            exp_res = model(in_data ^ (ADDKEY ? round_key : 128'd0));
            acc_q.push_back(cyc);
         end else if (pending && (cyc >= acc_cyc + 5) && out_ready) begin
            pending = 1'b0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic push(input logic [127:0] d, input logic [127:0] k, input bit hold);
      int t;
      in_data   = d;
      round_key = k;
      in_valid  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("push_timeout", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Counts edges after the accept until out_valid is seen (posedge+1 sampling).
   task automatic wait_out(output logic [127:0] d, output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!out_valid && edges < 50);
      if (!out_valid) chk("wait_out_timeout", 128'(out_valid), 128'd1);
      d = out_data;
   endtask

   logic [127:0] d, held, r;
   int           e, s, t;
   bit           done;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      round_key = '0;

      // Pin the reference model with hand-computed values.
      chk("model_gmul_57_83", 128'(gmul(8'h57, 8'h83)), 128'h00c1);
      chk("model_vec1", model({4{32'hbca14d8e}}), {4{32'h455313db}});
      chk("model_vec2", model({32'h9d58dc9f, 32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6}),
          {32'h5c220af2, 32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6});
      chk("model_zero", model('0), '0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_out_data", out_data, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;

      // Repeated column, latency measurement.
      push({4{32'hbca14d8e}}, '0, 1'b0);
      wait_out(d, e);
      chk("vec1_latency", 128'(e), 128'd4);
      chk("vec1_data", d, {4{32'h455313db}});

      // Distinct columns.
      push({32'h9d58dc9f, 32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6}, '0, 1'b0);
      wait_out(d, e);
      chk("vec2_data", d, {32'h5c220af2, 32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6});

      // Backpressure: result held, new input ignored.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      r = rand128();
      push(r, '0, 1'b0);
      wait_out(held, e);
      chk("bp_data", held, model(r));
      in_data  = rand128();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_data", out_data, held);
         chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready", 128'(in_ready), 128'd1);

      // Reset two cycles after accept.
      push(rand128(), '0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'd0);
      chk("midrst_out_data", out_data, 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      r = rand128();
      push(r, '0, 1'b0);
      wait_out(d, e);
      chk("midrst_next_data", d, model(r));
      chk("midrst_next_latency", 128'(e), 128'd4);

      // Back-to-back with in_valid and out_ready held high.
      @(posedge clk);
      #1;
      s = acc_q.size();
      push(rand128(), '0, 1'b1);
      push(rand128(), '0, 1'b1);
      push(rand128(), '0, 1'b0);
      wait_out(d, e);
      @(posedge clk);
      #1;
      if (acc_q.size() >= s + 3) begin
         chk("b2b_spacing_1", 128'(acc_q[s+1] - acc_q[s]), 128'd6);
         chk("b2b_spacing_2", 128'(acc_q[s+2] - acc_q[s+1]), 128'd6);
      end else begin
         chk("b2b_accept_count", 128'(acc_q.size() - s), 128'd3);
      end

`ifdef AES_INVMIX_ADDKEY_EN
      push('0, {4{32'hbca14d8e}}, 1'b0);
      wait_out(d, e);
      chk("addkey_zero_in", d, {4{32'h455313db}});
      r = rand128();
      push(r, r, 1'b0);
      wait_out(d, e);
      chk("addkey_cancel", d, '0);
      @(posedge clk);
      #1;
`endif

      // Randomized traffic with random stalls and scrambled input after accept.
      for (int i = 0; i < 30; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
            in_data = rand128();
         end
         push(rand128(), rand128(), 1'b0);
         done = 1'b0;
         t = 0;
         while (!done && t < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            in_data   = rand128();
            @(negedge clk);
            if (out_valid && out_ready) done = 1'b1;
            @(posedge clk);
            #1;
            t++;
         end
         if (!done) chk("rand_handshake_timeout", 128'(done), 128'd1);
      end

      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_inv_mix_columns_seq.md
# aes_inv_mix_columns_seq

Column-serial AES InvMixColumns unit for the decryption path of the AES accelerator. It accepts a 128-bit state over a valid/ready handshake and applies the inverse column mix one 32-bit column per cycle. It presents the 128-bit result over a second valid/ready handshake. It pairs with the combinational forward MixColumns on the encryption path and uses the same byte and column packing, so states move between the two paths without reordering.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  unit can accept a state. High only in IDLE.
- in_data  input  128  state to transform. Column c is bits [32c+31:32c]; row r of a column is bits [8r+7:8r].
- round_key  input  128  present only with AES_INVMIX_ADDKEY_EN. Sampled together with in_data.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  transformed state, same packing as in_data.

## Operation
- Column math, with bytes a0..a3 of a column (a0 in the LSB) and GF(2^8) products reduced by x^8+x^4+x^3+x+1 (0x11B):
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - o1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - o2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - o3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Build the 0e, 0b, 0d and 09 multipliers from chained xtime: x2, x4, x8 plus XOR. No lookup tables.
- Only one column datapath is instantiated. It is time-shared across the four columns.
- Registers:
  - src (128): captured input.
  - res (128): result, which drives out_data.
  - col (2): column index.
  - state: one of three states below.
- States:
  - IDLE: in_ready=1. On in_valid, capture src←in_data, set col←0, go to BUSY.
  - BUSY: each cycle, write res column col ← InvMix(src column col), then col←col+1. The cycle that writes column 3 goes to DONE, and col wraps to 0.
  - DONE: out_valid=1. On out_ready, go to IDLE. Otherwise hold.
- in_valid outside IDLE is ignored; no data is captured.
- Changes on in_data after acceptance have no effect.
- out_data is stable while out_valid=1 and out_ready=0.
- During BUSY, res is partially updated. out_data is not meaningful while out_valid=0.
- out_ready outside DONE is ignored.
- Reset values: state=IDLE, in_ready=1 after reset release, out_valid=0, out_data=0, col=0, src=0.
- Asserting rst_n low in any state, including mid-BUSY, aborts the operation immediately. The partial result is discarded and all registers take their reset values.

## Timing
- The accept handshake is the rising edge where in_valid&&in_ready. Call it edge E0.
- Columns 0..3 are written at edges E1..E4.
- out_valid is high from E4 onward. Latency from accept to out_valid is 4 cycles.
- The output handshake completes at the first edge at or after E5 where out_ready=1. in_ready is high the cycle after that edge.
- With in_valid and out_ready held high, the unit accepts one state every 6 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- AES_INVMIX_ADDKEY_EN defined:
  - The round_key port exists.
  - IDLE captures src←in_data ^ round_key.
  - This fuses the decryption AddRoundKey ahead of InvMixColumns.
- Not defined:
  - The round_key port is absent.
  - src←in_data.
  - The unit is pure InvMixColumns.
- Latency and handshake are identical in both builds.

## Test plan
- All four columns 0xbca14d8e, with out_ready=1 → out_data 0x455313db repeated ×4. out_valid rises exactly 4 edges after accept.
- Columns {0x9d58dc9f, 0xd6d7d5d5, 0x01010101, 0xc6c6c6c6} (column 3 first), with out_ready=1 → out_data {0x5c220af2, 0xd5d4d4d4, 0x01010101, 0xc6c6c6c6}.
- Backpressure: out_ready=0 for 10 cycles after out_valid, while in_valid is held high with a new value → out_data unchanged, in_ready=0 throughout. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-BUSY: drop rst_n 2 cycles after accept → immediately out_valid=0, out_data=0, in_ready=1 after release. The next input produces a correct result.
- Back-to-back: 3 states with in_valid and out_ready held high → 3 correct results, accepts spaced exactly 6 cycles apart.
- With AES_INVMIX_ADDKEY_EN: in_data all-zero, round_key = 0xbca14d8e ×4 → 0x455313db ×4. in_data = round_key → all-zero output.
